// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the command dispatcher:
//   - state_e          : dispatcher FSM state encoding (ST_IDLE/ST_LOAD/ST_DROP)
//   - TGT_LSB/TGT_W    : position of the target engine index in the command byte
//   - bcast_bit()      : position of the broadcast flag (top bit of the command)
//   - engine_all_ready : true when every implemented engine is ready
// -----------------------------------------------------------------------------
package cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam int TGT_LSB     = 0;
    localparam int TGT_W       = 4;
    localparam int MAX_ENGINES = 16;

    // The broadcast flag is always the most significant command bit.
    function automatic int bcast_bit(input int cmd_w);
        return cmd_w - 1;
    endfunction

    // Lock-step broadcast pops only when every implemented engine is ready;
    // unimplemented lanes above num_engines are treated as ready.
    function automatic logic engine_all_ready(input logic [MAX_ENGINES-1:0] rtr,
                                              input int                   num_engines);
        logic [MAX_ENGINES-1:0] used;
        for (int i = 0; i < MAX_ENGINES; i++) begin
            used[i] = (i < num_engines);
        end
        return &(rtr | ~used);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous payload FIFO with a registered head word.
//   clk, rst  : clock, synchronous active-high reset (flushes the FIFO)
//   push      : write wr_data (ignored when full)
//   wr_data   : word to write
//   pop       : discard the head word (ignored when empty)
//   head      : registered head word; holds its last value when empty, 0 after reset
//   full      : DEPTH words stored
//   empty     : no words stored
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = head_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // The head register always mirrors the oldest stored word. After a pop
        // the next word is either already in memory or is the one being
        // written this cycle (single-entry push+pop, or push into empty).
        if (pop_ok) begin
            if (count_q > (AW+1)'(1)) begin
                head_d = mem_q[rd_ptr_d];
            end else if (push_ok) begin
                head_d = wr_data;
            end
        end else if (empty && push_ok) begin
            head_d = wr_data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, and leaving it unreset lets it map
    // onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// cmd_dispatcher
// Accepts a command header plus N payload words from the I2C front end and
// forwards the payload to one engine (unicast) or all engines in lock-step
// (broadcast). Headers with an out-of-range unicast target are flagged and
// their payload is swallowed.
//   clk, rst        : clock, synchronous active-high reset
//   in_rts/in_rtr   : upstream handshake (beat transfers when both high)
//   in_cmd          : command byte, sampled on header beats only
//   in_data         : header: low CNT_W bits = payload count N; else payload word
//   engine_in_rtr   : per-engine ready
//   engine_out_rts  : per-engine word valid
//   bcast_out_data  : shared data bus (registered FIFO head)
//   busy            : command in progress or payload still draining
//   err_cmd         : one-cycle pulse after an invalid header
//   cmd_count       : completed LOAD commands (only with CMD_DISPATCH_CNT_EN)
// Optional feature macro: CMD_DISPATCH_CNT_EN
// -----------------------------------------------------------------------------
module cmd_dispatcher
    import cmd_pkg::*;
#(
    parameter int NUM_ENGINES = 5,
    parameter int DATA_W      = 16,
    parameter int CMD_W       = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_rts,
    output logic                   in_rtr,
    input  logic [CMD_W-1:0]       in_cmd,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [NUM_ENGINES-1:0] engine_in_rtr,
    output logic [NUM_ENGINES-1:0] engine_out_rts,
    output logic [DATA_W-1:0]      bcast_out_data,
    output logic                   busy,
    output logic                   err_cmd
`ifdef CMD_DISPATCH_CNT_EN
    ,
    output logic [15:0]            cmd_count
`endif
);
    localparam int BCAST_BIT = bcast_bit(CMD_W);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
    logic             bcast_q, bcast_d;
    logic [TGT_W-1:0] tgt_q, tgt_d;
    logic             err_q, err_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              in_fire, load_done;

    logic             hdr_bcast;
    logic [TGT_W-1:0] hdr_tgt;
    logic [CNT_W-1:0] hdr_n;
    logic             unused_bits;

    assign hdr_bcast   = in_cmd[BCAST_BIT];
    assign hdr_tgt     = in_cmd[TGT_LSB +: TGT_W];
    assign hdr_n       = in_data[CNT_W-1:0];
    assign unused_bits = ^{in_cmd, in_data};

    cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output side: the FIFO only holds words while a LOAD is active, so the
    // latched target/bcast always belong to the words in it.
    always_comb begin
        engine_out_rts = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            engine_out_rts[i] = !fifo_empty && (bcast_q || (int'(tgt_q) == i));
        end
        if (bcast_q) begin
            fifo_pop = !fifo_empty &&
                       engine_all_ready(MAX_ENGINES'(engine_in_rtr), NUM_ENGINES);
        end else begin
            fifo_pop = |(engine_out_rts & engine_in_rtr);
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        acc_d     = acc_q;
        pop_cnt_d = pop_cnt_q;
        bcast_d   = bcast_q;
        tgt_d     = tgt_q;
        err_d     = 1'b0;
        fifo_push = 1'b0;
        load_done = 1'b0;

        case (state_q)
            ST_IDLE: in_rtr = fifo_empty;
            ST_LOAD: in_rtr = !fifo_full && (acc_q < n_q);
            ST_DROP: in_rtr = 1'b1;
            default: in_rtr = 1'b0;
        endcase
        if (rst) in_rtr = 1'b0;
        in_fire = in_rts && in_rtr;

        case (state_q)
            ST_IDLE: begin
                if (in_fire && (hdr_n != '0)) begin
                    n_d       = hdr_n;
                    acc_d     = '0;
                    pop_cnt_d = '0;
                    if (!hdr_bcast && (int'(hdr_tgt) >= NUM_ENGINES)) begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        bcast_d = hdr_bcast;
                        tgt_d   = hdr_tgt;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                fifo_push = in_fire;
                if (in_fire)  acc_d     = acc_q + CNT_W'(1);
                if (fifo_pop) pop_cnt_d = pop_cnt_q + CNT_W'(1);
                // Done only once every word is both accepted and delivered.
                if ((acc_d == n_q) && (pop_cnt_d == n_q)) begin
                    load_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (in_fire) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_d == n_q) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            acc_q     <= '0;
            pop_cnt_q <= '0;
            bcast_q   <= 1'b0;
            tgt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            pop_cnt_q <= pop_cnt_d;
            bcast_q   <= bcast_d;
            tgt_q     <= tgt_d;
            err_q     <= err_d;
        end
    end

    assign bcast_out_data = fifo_head;
    assign err_cmd        = err_q;
    assign busy           = (state_q != ST_IDLE) || !fifo_empty;

`ifdef CMD_DISPATCH_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_done) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cmd_count = cnt_q;
`endif

endmodule

// File: tb/tb_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_cmd_dispatcher
// Directed bench for cmd_dispatcher with default parameters. Inputs change and
// outputs are sampled just after the falling edge; the DUT acts on the rising
// edge in between.
// -----------------------------------------------------------------------------
module tb_cmd_dispatcher;
    localparam int NUM_ENGINES = 5;
    localparam int DATA_W      = 16;
    localparam int CMD_W       = 8;
    localparam int FIFO_DEPTH  = 8;
    localparam int CNT_W       = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_rts;
    logic                   in_rtr;
    logic [CMD_W-1:0]       in_cmd;
    logic [DATA_W-1:0]      in_data;
    logic [NUM_ENGINES-1:0] engine_in_rtr;
    logic [NUM_ENGINES-1:0] engine_out_rts;
    logic [DATA_W-1:0]      bcast_out_data;
    logic                   busy;
    logic                   err_cmd;
`ifdef CMD_DISPATCH_CNT_EN
    logic [15:0]            cmd_count;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    cmd_dispatcher #(
        .NUM_ENGINES (NUM_ENGINES),
        .DATA_W      (DATA_W),
        .CMD_W       (CMD_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_rts         (in_rts),
        .in_rtr         (in_rtr),
        .in_cmd         (in_cmd),
        .in_data        (in_data),
        .engine_in_rtr  (engine_in_rtr),
        .engine_out_rts (engine_out_rts),
        .bcast_out_data (bcast_out_data),
        .busy           (busy),
        .err_cmd        (err_cmd)
`ifdef CMD_DISPATCH_CNT_EN
        ,
        .cmd_count      (cmd_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [4:0] rts,
                             input logic [15:0] data, input logic bsy);
        check({tag, "_rts"},  32'(engine_out_rts), 32'(rts));
        check({tag, "_data"}, 32'(bcast_out_data), 32'(data));
        check({tag, "_busy"}, 32'(busy),           32'(bsy));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic rts, input logic [7:0] cmd, input logic [15:0] data);
        in_rts  = rts;
        in_cmd  = cmd;
        in_data = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  sent;
        int  recv;
        bit  done;

        // ---------------- reset ----------------
        rst           = 1'b1;
        engine_in_rtr = '0;
        drive(1'b0, 8'h00, 16'h0000);
        tick();
        tick();
        check("rst_in_rtr", 32'(in_rtr), 0);
        check("rst_err",    32'(err_cmd), 0);
        check_out("rst", 5'b00000, 16'h0000, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_in_rtr", 32'(in_rtr), 1);

        // ---------------- 1: unicast to engine 2, N=4 ----------------
        engine_in_rtr = 5'b00100;
        drive(1'b1, 8'h02, 16'h0004);
        tick();
        check("t1_hdr_busy", 32'(busy), 1);
        check("t1_hdr_rts",  32'(engine_out_rts), 0);
        check("t1_rtr",      32'(in_rtr), 1);
        drive(1'b1, 8'h02, 16'h000C);
        tick();
        check_out("t1_w0", 5'b00100, 16'h000C, 1'b1);
        drive(1'b1, 8'h02, 16'h000D);
        tick();
        check_out("t1_w1", 5'b00100, 16'h000D, 1'b1);
        drive(1'b1, 8'h02, 16'h000E);
        tick();
        check_out("t1_w2", 5'b00100, 16'h000E, 1'b1);
        drive(1'b1, 8'h02, 16'h000F);
        tick();
        check_out("t1_w3", 5'b00100, 16'h000F, 1'b1);
        check("t1_rtr_all_taken", 32'(in_rtr), 0);
        drive(1'b0, 8'h00, 16'h0000);
        tick();
        check_out("t1_end", 5'b00000, 16'h000F, 1'b0);
`ifdef CMD_DISPATCH_CNT_EN
        check("t1_count", 32'(cmd_count), 1);
`endif

        // ---------------- 2: broadcast N=3, engine 4 stalled ----------------
        engine_in_rtr = 5'b01111;
        drive(1'b1, 8'h80, 16'h0003);
        tick();
        check("t2_rtr", 32'(in_rtr), 1);
        drive(1'b1, 8'h80, 16'h0021);
        tick();
        check_out("t2_s1", 5'b11111, 16'h0021, 1'b1);
        drive(1'b1, 8'h80, 16'h0022);
        tick();
        check_out("t2_s2", 5'b11111, 16'h0021, 1'b1);
        drive(1'b1, 8'h80, 16'h0023);
        tick();
        check_out("t2_s3", 5'b11111, 16'h0021, 1'b1);
        drive(1'b0, 8'h00, 16'h0000);
        tick();
        check_out("t2_s4", 5'b11111, 16'h0021, 1'b1);
        check("t2_rtr_done", 32'(in_rtr), 0);
        tick();
        check_out("t2_s5", 5'b11111, 16'h0021, 1'b1);
        engine_in_rtr = 5'b11111;
        tick();
        check_out("t2_d1", 5'b11111, 16'h0022, 1'b1);
        tick();
        check_out("t2_d2", 5'b11111, 16'h0023, 1'b1);
        tick();
        check_out("t2_end", 5'b00000, 16'h0023, 1'b0);

        // ---------------- 3: invalid target 7, N=2 ----------------
        drive(1'b1, 8'h07, 16'h0002);
        tick();
        check("t3_err_pulse", 32'(err_cmd), 1);
        check_out("t3_h", 5'b00000, 16'h0023, 1'b1);
        drive(1'b1, 8'h07, 16'hAAAA);
        tick();
        check("t3_err_once", 32'(err_cmd), 0);
        check("t3_rtr", 32'(in_rtr), 1);
        check_out("t3_d1", 5'b00000, 16'h0023, 1'b1);
        drive(1'b1, 8'h07, 16'hBBBB);
        tick();
        check("t3_err_low", 32'(err_cmd), 0);
        check_out("t3_end", 5'b00000, 16'h0023, 1'b0);
        drive(1'b0, 8'h00, 16'h0000);

        // ---------------- 4: N=0 no-op, then target 0 N=1 ----------------
        drive(1'b1, 8'h00, 16'h0000);
        tick();
        check("t4_noop_err",  32'(err_cmd), 0);
        check("t4_noop_busy", 32'(busy), 0);
        check("t4_noop_rtr",  32'(in_rtr), 1);
        drive(1'b1, 8'h00, 16'h0001);
        tick();
        check("t4_hdr_err", 32'(err_cmd), 0);
        check_out("t4_h", 5'b00000, 16'h0023, 1'b1);
        drive(1'b1, 8'h00, 16'h5555);
        tick();
        check_out("t4_w", 5'b00001, 16'h5555, 1'b1);
        drive(1'b0, 8'h00, 16'h0000);
        tick();
        check_out("t4_end", 5'b00000, 16'h5555, 1'b0);

        // ---------------- 5: N=12 with engine 1 stalled ----------------
        engine_in_rtr = 5'b00000;
        drive(1'b1, 8'h01, 16'h000C);
        tick();
        for (int k = 0; k < 8; k++) begin
            check("t5_rtr_open", 32'(in_rtr), 1);
            drive(1'b1, 8'h01, 16'(16'h0100 + k));
            tick();
        end
        check("t5_rtr_full", 32'(in_rtr), 0);
        check_out("t5_full", 5'b00010, 16'h0100, 1'b1);
        drive(1'b1, 8'h01, 16'h0108);
        tick();
        check("t5_rtr_full2", 32'(in_rtr), 0);
        engine_in_rtr = 5'b00010;
        tick();
        check("t5_rtr_reopen", 32'(in_rtr), 1);
        sent = 8;
        recv = 1;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (engine_out_rts != '0) begin
                check("t5_rts",   32'(engine_out_rts), 32'(5'b00010));
                check("t5_order", 32'(bcast_out_data), 32'(16'h0100 + recv));
                recv++;
            end
            if (recv == 12) begin
                done   = 1'b1;
                in_rts = 1'b0;
            end else if (in_rtr && sent < 12) begin
                drive(1'b1, 8'h01, 16'(16'h0100 + sent));
                sent++;
            end else begin
                in_rts = 1'b0;
            end
            tick();
        end
        check("t5_all_received", 32'(done), 1);
        check_out("t5_end", 5'b00000, 16'h010B, 1'b0);
`ifdef CMD_DISPATCH_CNT_EN
        check("t5_count", 32'(cmd_count), 4);
`endif

        // ---------------- 6: reset mid-LOAD ----------------
        engine_in_rtr = 5'b00000;
        drive(1'b1, 8'h03, 16'h0004);
        tick();
        drive(1'b1, 8'h03, 16'h0077);
        tick();
        check_out("t6_w0", 5'b01000, 16'h0077, 1'b1);
        drive(1'b1, 8'h03, 16'h0078);
        tick();
        drive(1'b0, 8'h00, 16'h0000);
        rst = 1'b1;
        #1;
        check("t6_rtr_in_rst", 32'(in_rtr), 0);
        tick();
        check("t6_rst_rtr", 32'(in_rtr), 0);
        check("t6_rst_err", 32'(err_cmd), 0);
        check_out("t6_rst", 5'b00000, 16'h0000, 1'b0);
`ifdef CMD_DISPATCH_CNT_EN
        check("t6_rst_count", 32'(cmd_count), 0);
`endif
        rst = 1'b0;
        #1;
        check("t6_rtr_after", 32'(in_rtr), 1);
        engine_in_rtr = 5'b01000;
        drive(1'b1, 8'h03, 16'h0001);
        tick();
        drive(1'b1, 8'h03, 16'h0099);
        tick();
        check_out("t6_new", 5'b01000, 16'h0099, 1'b1);
        drive(1'b0, 8'h00, 16'h0000);
        tick();
        check_out("t6_end", 5'b00000, 16'h0099, 1'b0);
`ifdef CMD_DISPATCH_CNT_EN
        check("t6_count", 32'(cmd_count), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_dispatcher.md
Name: cmd_dispatcher

Overview:
- Parametrised successor to the command processor.
- Accepts command headers and payload words from the I2C front end over an rts/rtr handshake, and buffers the payload in an internal FIFO.
- Dispatches each payload to one engine (unicast) or all engines (broadcast) over per-engine rts/rtr handshakes, with variable command length and stall tolerance.
- Sits between the I2C slave and the graphics engine array.

Parameters:
- NUM_ENGINES, 5, number of engine channels (1..16).
- DATA_W, 16, data word width.
- CMD_W, 8, command byte width (minimum 5).
- FIFO_DEPTH, 8, payload FIFO depth; power of 2, at least 2.
- CNT_W, 8, width of the payload word-count field.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_rts  in  1  upstream has a word valid.
- in_rtr  out  1  dispatcher can accept a word.
- in_cmd  in  CMD_W  command byte; sampled on header beats only.
- in_data  in  DATA_W  header: low CNT_W bits are the payload word count; payload beat: data.
- engine_in_rtr  in  NUM_ENGINES  engine i is ready to receive.
- engine_out_rts  out  NUM_ENGINES  word valid for engine i.
- bcast_out_data  out  DATA_W  shared data bus to all engines.
- busy  out  1  a command is in progress.
- err_cmd  out  1  one-cycle pulse when a header is invalid.

Behaviour:
- Transfer rules:
  - An input beat transfers when in_rts && in_rtr.
  - An output word to engine i transfers when engine_out_rts[i] && engine_in_rtr[i].
- Header decode:
  - in_cmd[CMD_W-1] = bcast.
  - in_cmd[3:0] = target index.
  - in_data[CNT_W-1:0] = N, the number of payload words.
- States: IDLE, LOAD, DROP.
  - IDLE: in_rtr=1. A transferred beat is a header.
    - N==0: no-op; stay in IDLE.
    - Not bcast and target >= NUM_ENGINES: pulse err_cmd the next cycle, then go to DROP.
    - Otherwise: latch bcast, target and N; go to LOAD.
  - LOAD: in_rtr = !fifo_full && (accepted < N). Each accepted beat is pushed to the FIFO.
    - Leave for IDLE when all N words are accepted AND all N words are popped.
  - DROP: in_rtr=1. Accept and discard N words, then go to IDLE. No engine sees any data.
- In IDLE, in_rtr also requires that the FIFO is empty. A new header is never accepted while an earlier payload is still draining.
- Output side:
  - bcast_out_data is the registered FIFO head. engine_out_rts is asserted only while the FIFO is non-empty.
  - Unicast: only engine_out_rts[target]=1. Pop on engine_in_rtr[target].
  - Broadcast: all engine_out_rts bits = 1. Pop only when engine_in_rtr is all-ones (lock-step). Any engine that is not ready stalls every engine.
- Latency: a payload word accepted in cycle t is valid on bcast_out_data/engine_out_rts in cycle t+1 when the FIFO was empty.
- Throughput: one word per cycle when the target is always ready.
- Simultaneous push and pop on a full FIFO: push is blocked, because in_rtr is already 0. On a one-entry FIFO, push and pop in the same cycle keep the count unchanged.
- Counters: the accepted and popped counters are CNT_W bits. N = 2^CNT_W-1 must not wrap.
- busy = (state != IDLE) || !fifo_empty.
- Reset: state=IDLE, FIFO flushed, counters cleared. All outputs go to 0 (in_rtr is 0 during reset, 1 in the first cycle after). A reset mid-command discards the in-flight words; no partial command resumes.
- bcast_out_data holds its last value when the FIFO is empty. It reads 0 after reset.

Optional Feature:
- Macro: CMD_DISPATCH_CNT_EN.
- With the macro: adds output cmd_count[15:0]. It increments by 1 when a LOAD command completes, and never on DROP or no-op. It wraps at 16'hFFFF -> 0 and resets to 0.
- Without the macro: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package cmd_pkg holds:
  - state encoding constants ST_IDLE/ST_LOAD/ST_DROP;
  - the header field positions (BCAST_BIT=CMD_W-1, TGT_LSB=0, TGT_W=4);
  - the ENGINE_ALL_READY helper.
- One sub-module: cmd_fifo (synchronous FIFO, DATA_W x FIFO_DEPTH, with full/empty flags and a registered head output).

Test Plan:
1. Unicast to target 2: header N=4, then 0xC/0xD/0xE/0xF, with engine 2 always ready -> engine_out_rts=5'b00100 for 4 consecutive cycles, data C,D,E,F in order; busy falls after the last pop.
2. Broadcast, N=3, engine 4 holds rtr low for 5 cycles -> no pops while it is low and all rts bits stay high; FIFO fills to 3; the words deliver only after engine 4 is ready; no duplicates.
3. Invalid target 7 with NUM_ENGINES=5, N=2 -> err_cmd pulses exactly 1 cycle; both words are accepted and dropped; engine_out_rts stays 0.
4. Header with N=0, then a valid header for target 0, N=1 -> the first is a no-op (no err_cmd); the second delivers 1 word to engine 0.
5. Back-pressure: N=12 while engine 1 is stalled -> in_rtr drops once 8 words are buffered; it reasserts on the first pop; all 12 words arrive in order.
6. rst pulsed mid-LOAD after 2 of 4 words -> all outputs are 0 the next cycle and in_rtr=1 the cycle after; a new command then runs cleanly; with CMD_DISPATCH_CNT_EN, cmd_count=0 after the reset and 1 after the new command.
